imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_decode_stage.sv | 112 +++++++++++
 tb/tb_imm_decode_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// RV32I immediate-format decode stage with a two-entry skid buffer.
// Each entry holds the decoded extender select, all immediate slices and the PC.
module imm_decode_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        out_ready_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  output logic [2:0]  extend_o,
  output logic [19:0] u_type_o,
  output logic [20:0] j_type_o,
  output logic [12:0] b_type_o,
  output logic [11:0] s_type_o,
  output logic [11:0] i_type_o,
  output logic [31:0] pc_o,
  output logic        illegal_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [2:0]  ext;
    logic        ill;
    logic [19:0] u;
    logic [20:0] j;
    logic [12:0] b;
    logic [11:0] s;
    logic [11:0] i;
    logic [31:0] pc;
  } entry_t;

  entry_t            mem_q [2];
  entry_t            dec;
  entry_t            head;
  logic              wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  always_comb begin
    dec     = '0;
    dec.ext = 3'b111;
    dec.ill = 1'b0;
    dec.u   = instr_i[31:12];
    dec.j   = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    dec.b   = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    dec.s   = {instr_i[31:25], instr_i[11:7]};
    dec.i   = instr_i[31:20];
    dec.pc  = pc_i;
    case (instr_i[6:0])
      7'b0110111, 7'b0010111:            dec.ext = 3'b000;
      7'b1101111:                        dec.ext = 3'b001;
      7'b1100011:                        dec.ext = 3'b010;
      7'b0100011:                        dec.ext = 3'b011;
      7'b0000011, 7'b0010011, 7'b1100111: dec.ext = 3'b100;
      7'b0110011:                        dec.ext = 3'b111;
      default:                           dec.ill = 1'b1;
    endcase
  end

  // in_ready depends only on the registered count, so out_ready_i never reaches it.
  assign in_ready_o  = (count_q < CNT_W'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else if (flush_i) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Storage is unreset; an empty buffer masks it at the outputs.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  assign head      = mem_q[rd_ptr_q];
  assign extend_o  = out_valid_o ? head.ext : 3'b111;
  assign illegal_o = out_valid_o ? head.ill : 1'b0;
  assign u_type_o  = out_valid_o ? head.u   : '0;
  assign j_type_o  = out_valid_o ? head.j   : '0;
  assign b_type_o  = out_valid_o ? head.b   : '0;
  assign s_type_o  = out_valid_o ? head.s   : '0;
  assign i_type_o  = out_valid_o ? head.i   : '0;
  assign pc_o      = out_valid_o ? head.pc  : '0;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: directed scenarios plus random traffic, with a
// queue-based reference model and a negedge monitor checking every cycle.
module tb_imm_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic        out_ready_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic [2:0]  extend_o;
  logic [19:0] u_type_o;
  logic [20:0] j_type_o;
  logic [12:0] b_type_o;
  logic [11:0] s_type_o;
  logic [11:0] i_type_o;
  logic [31:0] pc_o;
  logic        illegal_o;

  int total = 0;
  int bad   = 0;

  // Each expected entry is {instr, pc}; the monitor derives the fields itself.
  logic [63:0] exp_q[$];

  imm_decode_stage #(.DEPTH(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_i(instr_i), .pc_i(pc_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .out_ready_i(out_ready_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .extend_o(extend_o),
    .u_type_o(u_type_o), .j_type_o(j_type_o), .b_type_o(b_type_o),
    .s_type_o(s_type_o), .i_type_o(i_type_o), .pc_o(pc_o), .illegal_o(illegal_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_ext(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    if (op == 7'h37 || op == 7'h17) return 3'd0;
    if (op == 7'h6F) return 3'd1;
    if (op == 7'h63) return 3'd2;
    if (op == 7'h23) return 3'd3;
    if (op == 7'h03 || op == 7'h13 || op == 7'h67) return 3'd4;
    return 3'd7;
  endfunction

  function automatic logic ref_ill(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return !(op inside {7'h37, 7'h17, 7'h6F, 7'h63, 7'h23, 7'h03, 7'h13, 7'h67, 7'h33});
  endfunction

  // Immediates rebuilt as sign-free bit values from the RV32I field definitions.
  function automatic logic [31:0] ref_j(input logic [31:0] ins);
    return (32'(ins[31]) << 20) + (32'(ins[19:12]) << 12) + (32'(ins[20]) << 11)
         + (32'(ins[30:21]) << 1);
  endfunction

  function automatic logic [31:0] ref_b(input logic [31:0] ins);
    return (32'(ins[31]) << 12) + (32'(ins[7]) << 11) + (32'(ins[30:25]) << 5)
         + (32'(ins[11:8]) << 1);
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q.delete();
    end else if (flush_i) begin
      exp_q.delete();
    end else begin
      int pre;
      pre = exp_q.size();
      if (out_ready_i && pre > 0) void'(exp_q.pop_front());
      if (in_valid_i && pre < 2) exp_q.push_back({instr_i, pc_i});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_i) begin
    chk("out_valid", 32'(out_valid_o), 32'(exp_q.size() != 0));
    chk("in_ready", 32'(in_ready_o), 32'(exp_q.size() < 2));
    if (exp_q.size() != 0) begin
      logic [31:0] ins, pc;
      {ins, pc} = exp_q[0];
      chk("extend", 32'(extend_o), 32'(ref_ext(ins)));
      chk("illegal", 32'(illegal_o), 32'(ref_ill(ins)));
      chk("u_type", 32'(u_type_o), ins >> 12);
      chk("j_type", 32'(j_type_o), ref_j(ins));
      chk("b_type", 32'(b_type_o), ref_b(ins));
      chk("s_type", 32'(s_type_o), (32'(ins[31:25]) << 5) + 32'(ins[11:7]));
      chk("i_type", 32'(i_type_o), ins >> 20);
      chk("pc", pc_o, pc);
    end else begin
      chk("idle_extend", 32'(extend_o), 32'd7);
      chk("idle_data", {pc_o[31:1], illegal_o} | 32'(u_type_o) | 32'(j_type_o)
          | 32'(b_type_o) | 32'(s_type_o) | 32'(i_type_o) | 32'(pc_o[0]), 32'd0);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    in_valid_i  = v;
    instr_i     = ins;
    pc_i        = pc;
    out_ready_i = ordy;
    flush_i     = fl;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h63, 7'h23, 7'h03, 7'h13, 7'h67, 7'h33, 7'h7F};
    w = $urandom;
    if ($urandom_range(0, 4) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  initial begin
    #1;
    chk("reset_valid", 32'(out_valid_o), 32'd0);
    chk("reset_ready", 32'(in_ready_o), 32'd1);
    chk("reset_extend", 32'(extend_o), 32'd7);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle(1);

    // Single LUI then back-to-back push+pop at count 1
    step(1'b1, 32'h92649237, 32'h100, 1'b1, 1'b0);
    chk("lui_valid", 32'(out_valid_o), 32'd1);
    chk("lui_ext", 32'(extend_o), 32'd0);
    chk("lui_u", 32'(u_type_o), 32'h92649);
    chk("lui_pc", pc_o, 32'h100);
    chk("lui_ill", 32'(illegal_o), 32'd0);
    step(1'b1, 32'h0C80006F, 32'h104, 1'b1, 1'b0);
    chk("jal_ext", 32'(extend_o), 32'd1);
    chk("jal_j", 32'(j_type_o), 32'h000C8);
    step(1'b1, 32'hFE000EE3, 32'h108, 1'b1, 1'b0);
    chk("beq_ext", 32'(extend_o), 32'd2);
    chk("beq_b", 32'(b_type_o), 32'h1FFC);
    chk("beq_valid", 32'(out_valid_o), 32'd1);
    step(1'b1, 32'h00112623, 32'h10C, 1'b1, 1'b0);
    chk("sw_ext", 32'(extend_o), 32'd3);
    chk("sw_s", 32'(s_type_o), 32'h00C);
    step(1'b1, 32'hFFF00093, 32'h110, 1'b1, 1'b0);
    chk("addi_ext", 32'(extend_o), 32'd4);
    chk("addi_i", 32'(i_type_o), 32'hFFF);
    chk("addi_pc", pc_o, 32'h110);
    idle(2);

    // Backpressure: three pushes with out_ready low
    step(1'b1, 32'h00000013, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h00100013, 32'h204, 1'b0, 1'b0);
    chk("full_ready", 32'(in_ready_o), 32'd0);
    step(1'b1, 32'h00200013, 32'h208, 1'b0, 1'b0);
    chk("full_hold_pc", pc_o, 32'h200);
    step(1'b1, 32'h00200013, 32'h208, 1'b1, 1'b0);
    chk("pop1_pc", pc_o, 32'h204);
    chk("pop1_ready", 32'(in_ready_o), 32'd1);
    step(1'b1, 32'h00200013, 32'h208, 1'b1, 1'b0);
    chk("third_pc", pc_o, 32'h208);
    idle(2);

    // Flush while full, with a valid input in the flush cycle
    step(1'b1, 32'h00000013, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00000013, 32'h304, 1'b0, 1'b0);
    step(1'b1, 32'h00000013, 32'h308, 1'b0, 1'b1);
    chk("flush_valid", 32'(out_valid_o), 32'd0);
    chk("flush_ready", 32'(in_ready_o), 32'd1);
    chk("flush_ext", 32'(extend_o), 32'd7);

    // Illegal opcode, then R-type, then async reset mid-stream
    step(1'b1, 32'h0000007F, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h002081B3, 32'h404, 1'b0, 1'b0);
    chk("bad_ill", 32'(illegal_o), 32'd1);
    chk("bad_ext", 32'(extend_o), 32'd7);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("add_ill", 32'(illegal_o), 32'd0);
    chk("add_ext", 32'(extend_o), 32'd7);
    step(1'b1, 32'h00000013, 32'h500, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid_o), 32'd0);
    chk("async_rst_ready", 32'(in_ready_o), 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    step(1'b1, 32'h00500093, 32'h600, 1'b0, 1'b0);
    chk("post_rst_pc", pc_o, 32'h600);
    idle(2);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
